// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// handshakes with instruction/data memory and times the datapath enables.
module multicycle_sequencer #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  output logic             imem_req_o,
  input  logic             imem_ack_i,
  output logic             ir_load_o,
  input  logic             reg_read_i,
  input  logic             reg_write_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic             branch_i,
  output logic             alu_en_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_ack_i,
  output logic             rf_we_o,
  output logic             pc_load_o,
  output logic             pc_sel_o,
  output logic [2:0]       state_o,
  output logic             busy_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int WT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  // reg_read only matters for the legality check in DECODE, so it is not kept.
  typedef struct packed {
    logic rw;
    logic mr;
    logic mw;
    logic br;
  } flags_t;

  state_t           state_q, state_d;
  flags_t           flags_q, flags_d;
  logic [WT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             tmo;
  logic             mem_op;

  assign mem_op = flags_q.mr | flags_q.mw;
  // Asserted on the last un-acked cycle allowed; an ack on that same cycle still wins.
  assign tmo    = (wait_q == WT_W'(TIMEOUT_CYC - 1));

  // State, latched flags, wait counter and retire counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      flags_q   <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, flag latch, timeout counter and retire bookkeeping.
  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE:   if (run_i) state_d = S_FETCH;
      S_FETCH:  begin
        if (imem_ack_i) state_d = S_DECODE;
        else if (tmo)   state_d = S_FAULT;
      end
      S_DECODE: begin
        flags_d = '{rw: reg_write_i, mr: mem_read_i, mw: mem_write_i, br: branch_i};
        if (!(reg_read_i | reg_write_i | mem_read_i | mem_write_i | branch_i))
          state_d = S_FAULT;
        else
          state_d = S_EXEC;
      end
      S_EXEC:   begin
        if (mem_op)          state_d = S_MEM;
        else if (flags_q.rw) state_d = S_WB;
        else                 retire  = 1'b1;
      end
      S_MEM:    begin
        // A set mem_write makes it a store even when mem_read is also set.
        if (dmem_ack_i) begin
          if (flags_q.mw) retire  = 1'b1;
          else            state_d = S_WB;
        end else if (tmo) begin
          state_d = S_FAULT;
        end
      end
      S_WB:     retire = 1'b1;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
    if (retire) state_d = run_i ? S_FETCH : S_IDLE;

    // Count only while staying in a request state; any entry restarts from zero.
    if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q)
      wait_d = wait_q + WT_W'(1);
    else
      wait_d = '0;

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  // Strobes decoded from the current state; FAULT leaves all of them low.
  always_comb begin
    imem_req_o = (state_q == S_FETCH);
    ir_load_o  = (state_q == S_FETCH) & imem_ack_i;
    alu_en_o   = (state_q == S_EXEC);
    dmem_req_o = (state_q == S_MEM);
    dmem_we_o  = (state_q == S_MEM) & flags_q.mw;
    rf_we_o    = (state_q == S_WB);
    pc_load_o  = retire;
    pc_sel_o   = retire & flags_q.br;
    state_o    = state_q;
    busy_o     = (state_q != S_IDLE);
    fault_o    = (state_q == S_FAULT);
    retired_o  = retired_q;
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench: each instruction is expanded into its expected per-cycle
// trace (from flags and ack wait counts), then replayed against the DUT.
module tb_multicycle_sequencer;
  localparam int TMO = 16;
  localparam int CW  = 4;

  logic clk = 0, rst = 1, run = 0, imem_ack = 0, dmem_ack = 0;
  logic reg_read = 0, reg_write = 0, mem_read = 0, mem_write = 0, branch = 0;
  logic imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, pc_load, pc_sel, busy, fault;
  logic [2:0] state;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  multicycle_sequencer #(.TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run),
    .imem_req_o(imem_req), .imem_ack_i(imem_ack), .ir_load_o(ir_load),
    .reg_read_i(reg_read), .reg_write_i(reg_write), .mem_read_i(mem_read),
    .mem_write_i(mem_write), .branch_i(branch),
    .alu_en_o(alu_en), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_ack_i(dmem_ack),
    .rf_we_o(rf_we), .pc_load_o(pc_load), .pc_sel_o(pc_sel),
    .state_o(state), .busy_o(busy), .fault_o(fault), .retired_o(retired)
  );

  // One expected cycle: state/strobes to see, plus inputs to drive.
  typedef struct packed {
    logic [2:0] st;
    logic imreq, irld, alu, dreq, dwe, rfwe, pcld, pcsel;
    logic run, iack, dack;
    logic [4:0] fl;  // {reg_read, reg_write, mem_read, mem_write, branch}
  } cyc_t;

  cyc_t q[$];
  int   checks = 0, failures = 0, cyc = 0;
  int   rcnt = 0;
  bit   idle_next = 1, faulted = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic cyc_t mk(input logic [2:0] st);
    cyc_t c;
    c = '0;
    c.st   = st;
    c.run  = 1'($urandom);
    c.iack = 1'($urandom);
    c.dack = 1'($urandom);
    c.fl   = 5'($urandom);
    return c;
  endfunction

  task automatic add_fault();
    for (int k = 0; k < 4; k++) q.push_back(mk(3'd7));
    faulted = 1;
  endtask

  // Expand one instruction into its expected cycle trace.
  task automatic gen_instr(input logic [4:0] fl, input int wi, input int wd, input bit cont);
    cyc_t c;
    bit   mem, store;
    if (idle_next) begin
      int n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin c = mk(3'd0); c.run = 0; q.push_back(c); end
      c = mk(3'd0); c.run = 1; q.push_back(c);
      idle_next = 0;
    end
    for (int k = 0; k <= wi && k < TMO; k++) begin
      c = mk(3'd1); c.imreq = 1; c.iack = (k == wi); c.irld = c.iack; q.push_back(c);
    end
    if (wi >= TMO) begin add_fault(); return; end
    c = mk(3'd2); c.fl = fl; q.push_back(c);
    if (fl == 0) begin add_fault(); return; end
    store = fl[1];
    mem   = fl[2] | fl[1];
    c = mk(3'd3); c.alu = 1;
    if (!mem && !fl[3]) begin c.pcld = 1; c.pcsel = fl[0]; c.run = cont; idle_next = !cont; end
    q.push_back(c);
    if (mem) begin
      for (int k = 0; k <= wd && k < TMO; k++) begin
        c = mk(3'd4); c.dreq = 1; c.dwe = store; c.dack = (k == wd);
        if (c.dack && store) begin c.pcld = 1; c.pcsel = fl[0]; c.run = cont; idle_next = !cont; end
        q.push_back(c);
      end
      if (wd >= TMO) begin add_fault(); return; end
    end
    if ((mem && !store) || (!mem && fl[3])) begin
      c = mk(3'd5); c.rfwe = 1; c.pcld = 1; c.pcsel = fl[0]; c.run = cont; idle_next = !cont;
      q.push_back(c);
    end
  endtask

  // Replay up to 'limit' queued cycles, checking outputs mid-cycle.
  task automatic apply(input int limit);
    cyc_t c;
    logic [16:0] obs, exp;
    for (int i = 0; i < q.size() && i < limit; i++) begin
      c = q[i];
      @(posedge clk); #1;
      rst = 0; run = c.run; imem_ack = c.iack; dmem_ack = c.dack;
      {reg_read, reg_write, mem_read, mem_write, branch} = c.fl;
      @(negedge clk);
      cyc++;
      obs = {state, busy, fault, imem_req, ir_load, alu_en, dmem_req, dmem_we & dmem_req,
             rf_we, pc_load, pc_sel & pc_load, retired};
      exp = {c.st, c.st != 3'd0, c.st == 3'd7, c.imreq, c.irld, c.alu, c.dreq, c.dwe,
             c.rfwe, c.pcld, c.pcsel, 4'(rcnt)};
      chk($sformatf("cycle%0d", cyc), 32'(obs), 32'(exp));
      if (c.pcld) rcnt = (rcnt + 1) % (1 << CW);
    end
    q.delete();
  endtask

  task automatic do_reset();
    logic [16:0] obs;
    @(posedge clk); #1;
    rst = 1; run = 1'($urandom); imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    obs = {state, busy, fault, imem_req, ir_load, alu_en, dmem_req, dmem_we,
           rf_we, pc_load, pc_sel, retired};
    chk("reset", 32'(obs), 32'd0);
    rcnt = 0; idle_next = 1; faulted = 0;
  endtask

  function automatic int pickw();
    int r = $urandom_range(0, 29);
    if (r == 0) return TMO + $urandom_range(0, 3);
    if (r == 1) return TMO - 1;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    do_reset();
    // ALU op, load with 3 wait cycles, branch, store ending with run low.
    gen_instr(5'b11000, 0, 0, 1); apply(1000);
    gen_instr(5'b00100, 0, 3, 1); apply(1000);
    gen_instr(5'b00001, 0, 0, 1); apply(1000);
    gen_instr(5'b00010, 0, 2, 0); apply(1000);
    // Acks on the last allowed cycle, then both-set as store.
    gen_instr(5'b00100, TMO - 1, TMO - 1, 1); apply(1000);
    gen_instr(5'b00110, 1, 0, 1); apply(1000);
    // Fetch timeout, then illegal instruction.
    gen_instr(5'b11000, TMO, 0, 1); apply(1000); do_reset();
    gen_instr(5'b00000, 0, 0, 1); apply(1000); do_reset();
    // Randomized stream; counter wraps many times.
    for (int n = 0; n < 150; n++) begin
      logic [4:0] fl = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 19) == 0) fl = 5'd0;
      gen_instr(fl, pickw(), pickw(), $urandom_range(0, 3) != 0);
      if (faulted) begin
        apply(1000); do_reset();
      end else if ($urandom_range(0, 24) == 0) begin
        apply($urandom_range(1, q.size())); do_reset();
      end else begin
        apply(1000);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
